mac_accumulator: RTL

Streaming signed fixed-point accumulator that sits directly downstream of the NPU multiplier stage. It consumes one NBITS-wide product per cycle over a valid/ready handshake and sums the products of one vector in a guard-bit-extended register. On the vector's last element it produces a single NBITS result, saturated and optionally ReLU-clamped, in the same fixed-point format as the multiplier output. It is the reduction half of a dot-product lane; its output feeds activation storage or the next layer.

---
 rtl/mac_accumulator.sv | 116 +++++++++++
 1 files changed

// File: rtl/mac_accumulator.sv
// Streaming signed fixed-point accumulator: sums one vector of products in a
// guard-bit-extended register and emits a saturated, optionally ReLU'd result.
module mac_accumulator #(
    parameter int unsigned NBITS = 8,
    parameter int unsigned DBITS = 4,
    parameter int unsigned GBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_prod,
    input  logic             in_last,
    input  logic             relu_en,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_acc,
    output logic             out_sat
);

    localparam int unsigned ABITS = NBITS + GBITS;

    // Representable NBITS range, expressed at accumulator width for comparison
    localparam logic signed [ABITS-1:0] SUM_MAX = {{(GBITS + 1){1'b0}}, {(NBITS - 1){1'b1}}};
    localparam logic signed [ABITS-1:0] SUM_MIN = {{(GBITS + 1){1'b1}}, {(NBITS - 1){1'b0}}};
    localparam logic [NBITS-1:0]        RES_MAX = {1'b0, {(NBITS - 1){1'b1}}};
    localparam logic [NBITS-1:0]        RES_MIN = {1'b1, {(NBITS - 1){1'b0}}};

    // Fractional bits only document the format; accumulation is format-preserving
    if (DBITS >= NBITS || GBITS == 0) begin : g_param_check
        $error("mac_accumulator: need DBITS < NBITS and GBITS > 0");
    end

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic signed [ABITS-1:0] acc_q, acc_d;
    logic [NBITS-1:0]        out_acc_q, out_acc_d;
    logic                    out_sat_q, out_sat_d;

    logic signed [ABITS-1:0] prod_ext;
    logic signed [ABITS-1:0] sum;
    logic [NBITS-1:0]        sat_val;
    logic                    sat_flag;
    logic [NBITS-1:0]        relu_val;
    logic                    in_hs;

    assign in_rdy  = (state_q == ST_ACC);
    assign out_val = (state_q == ST_DONE);
    assign out_acc = out_acc_q;
    assign out_sat = out_sat_q;

    assign in_hs    = in_val && in_rdy;
    assign prod_ext = {{GBITS{in_prod[NBITS-1]}}, in_prod};
    assign sum      = acc_q + prod_ext;

    // Clip the guard-extended sum back to NBITS
    always_comb begin
        sat_val  = sum[NBITS-1:0];
        sat_flag = 1'b0;
        if (sum > SUM_MAX) begin
            sat_val  = RES_MAX;
            sat_flag = 1'b1;
        end else if (sum < SUM_MIN) begin
            sat_val  = RES_MIN;
            sat_flag = 1'b1;
        end
    end

    // ReLU follows saturation and does not alter the saturation flag
    assign relu_val = (relu_en && sat_val[NBITS-1]) ? '0 : sat_val;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        out_acc_d = out_acc_q;
        out_sat_d = out_sat_q;
        case (state_q)
            ST_ACC: begin
                if (in_hs) begin
                    if (in_last) begin
                        out_acc_d = relu_val;
                        out_sat_d = sat_flag;
                        acc_d     = '0;
                        state_d   = ST_DONE;
                    end else begin
                        acc_d = sum;
                    end
                end
            end
            ST_DONE: begin
                if (out_rdy) begin
                    state_d = ST_ACC;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            out_acc_q <= '0;
            out_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            out_acc_q <= out_acc_d;
            out_sat_q <= out_sat_d;
        end
    end

endmodule
